// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults, requester state encoding and register-slave address map.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_master_state_e;

  localparam logic [APB_ADDR_W-1:0] APB_REG0_ADDR = 32'h0000_1000;
  localparam logic [APB_ADDR_W-1:0] APB_REG1_ADDR = 32'h0000_1004;
  localparam logic [APB_ADDR_W-1:0] APB_REG2_ADDR = 32'h0000_1008;
  localparam logic [APB_ADDR_W-1:0] APB_REG3_ADDR = 32'h0000_100C;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts PREADY-low ACCESS cycles; expire_c_o flags the cycle in which the LIMIT-th such cycle occurs.
module apb_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_c_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  // Saturate at LIMIT so a stalled clear can never wrap the count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CW'(LIMIT))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c_o = inc_i && !clear_i && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: cmd valid/ready in, SETUP/ACCESS on APB, rsp valid/ready out.
// Optional ACCESS timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_param
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_master_state_e state_q, state_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_c;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .clear_i   (state_q != ACCESS),
    .inc_i     ((state_q == ACCESS) && !PREADY),
    .expire_c_o(timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state logic; bus/handshake flags are decoded from the next state so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A completing PREADY takes priority over an expiring timeout.
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          state_d     = RESP;
        end else if (timeout_c) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-beat commands from an internal valid/ready command port into APB SETUP/ACCESS transfers. It returns read data and error status on a valid/ready response port. It is the initiator paired with the team's APB register slaves and sits between bus-owning logic (sequencers, CPU bridge) and the APB fabric. There is one outstanding transfer at a time and no pipelining across transfers.

## Interface
- ADDR_W, 32, width of PADDR/cmd_addr
- DATA_W, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
- TIMEOUT_CYCLES, 16, PREADY-low cycles tolerated in ACCESS; only used with timeout compiled in; must be ≥1

Ports:
- PCLK  in  1  single clock, rising edge
- PRESETn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  PSLVERR captured, or timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB completer ready
- PSLVERR  in  1  APB completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid&&cmd_ready, latch write/addr/wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
- SETUP
  - PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS unconditionally.
- ACCESS
  - PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS.
  - PREADY=1: capture rsp_rdata = read ? PRDATA : 0 and rsp_err = PSLVERR, then go to RESP.
  - PSLVERR is sampled only when PREADY=1.
- RESP
  - PSEL=0, PENABLE=0, rsp_valid=1; rsp_rdata/rsp_err held stable.
  - On rsp_ready go to IDLE. rsp_valid must not drop without a handshake.
- cmd_ready is 0 in SETUP, ACCESS and RESP.
- PADDR/PWRITE/PWDATA stay constant from SETUP through the end of ACCESS. They keep their last value while idle (no toggling).
- Reset, including mid-transfer: all outputs immediately go to 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, cmd_ready=0 while PRESETn low). The FSM goes to IDLE and the in-flight command is dropped with no response.

## Timing
- Command accepted at edge N.
- SETUP is cycle N+1 and ACCESS starts at cycle N+2.
- With zero wait states, rsp_valid=1 from cycle N+3.
- Each PREADY-low cycle in ACCESS adds one cycle.
- Minimum command-to-command spacing is 4 cycles: accept, SETUP, ACCESS, RESP with rsp_ready=1. IDLE returns the following cycle.
- All outputs are registered or decoded from state only; there are no combinational paths from cmd_* or PREADY to outputs.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES with PREADY still 0, the FSM leaves ACCESS and goes to RESP with rsp_err=1, rsp_rdata=0.
  - PSEL/PENABLE drop in that RESP cycle.
  - If PREADY=1 arrives in the same cycle the limit is hit, normal completion wins.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter and no timeout; ACCESS waits indefinitely for PREADY. TIMEOUT_CYCLES is unused.

## Structure
- Shared package apb_pkg holds:
  - APB_ADDR_W and APB_DATA_W defaults (32).
  - apb_master_state_e enum (IDLE, SETUP, ACCESS, RESP).
  - Address constants for the register slave map (0x1000, 0x1004, 0x1008, 0x100C).
- One sub-module, apb_timeout_ctr: count, clear, expire output. It is instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write to 0x1004 with 0xDEADBEEF, slave PREADY=1:
  - cycle N+1: PSEL=1, PENABLE=0, PWRITE=1, PADDR=0x1004, PWDATA=0xDEADBEEF.
  - cycle N+2: PENABLE=1.
  - cycle N+3: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Read from 0x1004 after that write: rsp_rdata=0xDEADBEEF, rsp_err=0. A read of 0x1010 returns 0.
- PREADY held 0 for 3 ACCESS cycles: ACCESS lasts 4 cycles, PADDR/PWRITE stable throughout, rsp_valid at N+6.
- PSLVERR=1 with PREADY=1: rsp_err=1. PSLVERR=1 with PREADY=0 has no effect.
- rsp_ready held 0 for 5 cycles with cmd_valid=1: rsp_valid and data held, cmd_ready=0, PSEL stays 0. The next command is accepted the cycle after the handshake completes.
- PRESETn pulsed low mid-ACCESS: PSEL/PENABLE go to 0 before the next edge and no response is produced.
- Timeout with macro, TIMEOUT_CYCLES=4, PREADY stuck 0: rsp_err=1 after 4 ACCESS cycles.
- Timeout without macro, same stimulus: the master waits until PREADY=1.
